whack_game_ctrl: RTL

- Game sequencer for whack-a-mole: picks mole positions, drives the 8 mole LEDs, and times each mole using the level tick.
- Detects switch hits, keeps a 2-digit BCD score, and counts down the game clock.
- Sits between the clock dividers/switches and the display/scoring path; its led output feeds the LED pins and the score/display logic.

---
 rtl/whack_game_ctrl_if.sv | 30 +++
 rtl/whack_game_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_ctrl_if.sv
// Game-controller bundle: timing ticks, player controls, and LED/score/status outputs.
interface whack_game_ctrl_if;
  logic       tick_lev;
  logic       tick_1hz;
  logic       start;
  logic       pause;
  logic [7:0] switch;
  logic [7:0] led;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [6:0] time_left;
  logic       game_active;
  logic       game_over;
  logic       hit_pulse;
  logic       miss_pulse;

  // Stimulus side: drives ticks and controls, observes game outputs.
  modport master (
    output tick_lev, tick_1hz, start, pause, switch,
    input  led, score_ones, score_tens, time_left, game_active, game_over,
           hit_pulse, miss_pulse
  );

  // Controller side.
  modport slave (
    input  tick_lev, tick_1hz, start, pause, switch,
    output led, score_ones, score_tens, time_left, game_active, game_over,
           hit_pulse, miss_pulse
  );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole sequencer: spawns moles from an LFSR, times them on the level
// tick, scores hits in 2-digit BCD and runs the game countdown.
// Optional macro WHACK_MISS_PENALTY_EN: wrong switches and misses cost a point.
// Outputs are registered and follow the state that computed them by one cycle.
module whack_game_ctrl #(
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned MOLE_TICKS   = 4,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  whack_game_ctrl_if.slave  bus
);

  localparam int unsigned TIME_W = 7;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_UP, S_HIT, S_MISS, S_GAP, S_OVER
  } state_t;

  state_t              state, state_d;
  logic [7:0]          lfsr, lfsr_d;
  logic [2:0]          prev_idx, prev_idx_d;
  logic [CNT_W-1:0]    tick_cnt, tick_cnt_d;
  logic [7:0]          led_r, led_d;
  logic [7:0]          score, score_d;
  logic [TIME_W-1:0]   time_r, time_d;
  logic                active_r, active_d;
  logic                over_r, over_d;
  logic                hit_r, hit_d;
  logic                miss_r, miss_d;
  logic                start_q;
  logic [7:0]          switch_q;

  logic                start_rise;
  logic [7:0]          sw_rise;
  logic [2:0]          idx;
  logic                hit_c;
  logic                wrong_c;

  function automatic logic is_active(input state_t s);
    return (s == S_SPAWN) || (s == S_UP) || (s == S_HIT) ||
           (s == S_MISS) || (s == S_GAP);
  endfunction

  // BCD +1 with saturation at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s[3:0] == 4'd9) begin
      if (s[7:4] == 4'd9) return s;
      return {s[7:4] + 4'd1, 4'd0};
    end
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // BCD -1 with saturation at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s[3:0] == 4'd0) begin
      if (s[7:4] == 4'd0) return s;
      return {s[7:4] - 4'd1, 4'd9};
    end
    return {s[7:4], s[3:0] - 4'd1};
  endfunction

  // Input edge registers; these run even while paused so paused edges are lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      switch_q <= 8'd0;
    end else begin
      start_q  <= bus.start;
      switch_q <= bus.switch;
    end
  end

  // State and game registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_SEED;
      prev_idx <= 3'd0;
      tick_cnt <= '0;
      led_r    <= 8'd0;
      score    <= 8'h00;
      time_r   <= TIME_W'(GAME_SECONDS);
      active_r <= 1'b0;
      over_r   <= 1'b0;
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
    end else begin
      state    <= state_d;
      lfsr     <= lfsr_d;
      prev_idx <= prev_idx_d;
      tick_cnt <= tick_cnt_d;
      led_r    <= led_d;
      score    <= score_d;
      time_r   <= time_d;
      active_r <= active_d;
      over_r   <= over_d;
      hit_r    <= hit_d;
      miss_r   <= miss_d;
    end
  end

  // Next-state, timer, scoring and output computation.
  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    prev_idx_d = prev_idx;
    tick_cnt_d = tick_cnt;
    led_d      = led_r;
    score_d    = score;
    time_d     = time_r;
    active_d   = active_r;
    over_d     = over_r;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    start_rise = bus.start & ~start_q;
    sw_rise    = bus.switch & ~switch_q;
    idx        = lfsr[2:0];
    hit_c      = |(sw_rise & led_r);
    wrong_c    = |(sw_rise & ~led_r);

    if (!bus.pause) begin
      lfsr_d = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      if (is_active(state) && bus.tick_1hz && (time_r != '0))
        time_d = time_r - TIME_W'(1);

      // The last second ends the game ahead of anything else this cycle.
      if (is_active(state) && bus.tick_1hz && (time_r == TIME_W'(1))) begin
        state_d = S_OVER;
        led_d   = 8'd0;
      end else begin
        case (state)
          S_IDLE, S_OVER: begin
            led_d = 8'd0;
            if (start_rise) begin
              time_d  = TIME_W'(GAME_SECONDS);
              score_d = 8'h00;
              state_d = S_SPAWN;
            end
          end
          S_SPAWN: begin
            if (idx == prev_idx) idx = idx + 3'd1;
            led_d      = 8'(1) << idx;
            prev_idx_d = idx;
            tick_cnt_d = '0;
            state_d    = S_UP;
          end
          S_UP: begin
            if (bus.tick_lev) tick_cnt_d = tick_cnt + CNT_W'(1);
            if (hit_c) begin
              state_d = S_HIT;
            end else begin
`ifdef WHACK_MISS_PENALTY_EN
              if (wrong_c) score_d = bcd_dec(score);
`endif
              if (bus.tick_lev && (tick_cnt_d == CNT_W'(MOLE_TICKS)))
                state_d = S_MISS;
            end
          end
          S_HIT: begin
            hit_d   = 1'b1;
            led_d   = 8'd0;
            score_d = bcd_inc(score);
            state_d = S_GAP;
          end
          S_MISS: begin
            miss_d  = 1'b1;
            led_d   = 8'd0;
`ifdef WHACK_MISS_PENALTY_EN
            score_d = bcd_dec(score);
`endif
            state_d = S_GAP;
          end
          S_GAP: begin
            led_d = 8'd0;
            if (bus.tick_lev) state_d = S_SPAWN;
          end
          default: begin
            led_d   = 8'd0;
            state_d = S_IDLE;
          end
        endcase
      end

      active_d = is_active(state_d);
      over_d   = (state_d == S_OVER);
    end
  end

  assign bus.led         = led_r;
  assign bus.score_ones  = score[3:0];
  assign bus.score_tens  = score[7:4];
  assign bus.time_left   = time_r;
  assign bus.game_active = active_r;
  assign bus.game_over   = over_r;
  assign bus.hit_pulse   = hit_r;
  assign bus.miss_pulse  = miss_r;

endmodule
